// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions.
//   FB_WIDTH / FB_HEIGHT / FB_DEPTH : panel geometry, in 16-bit RGB565 words
//   ADDR_W / DATA_W / STARVE_W      : bus and counter widths
//   fb_state_e                      : write-arbiter FSM states
//   fb_in_range()                   : address bounds check shared by writers
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  function automatic logic fb_in_range(input logic [ADDR_W-1:0] addr,
                                       input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: merges camera and overlay (gfx) pixel writes
// onto a single frame-buffer write port, and can fill the whole buffer with
// one colour.
//   clk, reset_n                    : clock, async active-low reset
//   cam_valid/ready/addr/data       : camera write stream (priority requester)
//   gfx_valid/ready/addr/data       : overlay write stream (anti-starvation)
//   clr_start, clr_color            : fill request pulse and colour
//   clr_busy, clr_done              : fill in progress / completion pulse
//   fb_we, fb_wAddr, fb_wData       : registered frame-buffer write port
//   oob_err                         : sticky out-of-range write flag
module fb_write_arbiter #(
  parameter int unsigned FB_DEPTH     = fb_pkg::FB_DEPTH,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cam_valid,
  output logic        cam_ready,
  input  logic [16:0] cam_addr,
  input  logic [15:0] cam_data,
  input  logic        gfx_valid,
  output logic        gfx_ready,
  input  logic [16:0] gfx_addr,
  input  logic [15:0] gfx_data,
  input  logic        clr_start,
  input  logic [15:0] clr_color,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        fb_we,
  output logic [16:0] fb_wAddr,
  output logic [15:0] fb_wData,
  output logic        oob_err
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(FB_DEPTH - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

  fb_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                oob_q, oob_d;

  logic starve_hit, cam_grant, gfx_grant;

  assign starve_hit = 32'(starve_q) >= STARVE_LIMIT;

  // Readies depend only on state, the other requester's valid and the
  // starve counter, never on the requester's own address/data.
  always_comb begin
    cam_ready = 1'b0;
    gfx_ready = 1'b0;
    if (state_q == ARB) begin
      cam_ready = !starve_hit;
      gfx_ready = starve_hit || !cam_valid;
    end
  end

  assign cam_grant = cam_valid && cam_ready;
  assign gfx_grant = gfx_valid && gfx_ready;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    color_d = color_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    oob_d   = oob_q;
    unique case (state_q)
      ARB: begin
        if (cam_grant) begin
          addr_d = cam_addr;
          data_d = cam_data;
          we_d   = fb_in_range(cam_addr, FB_DEPTH);
          oob_d  = oob_q || !fb_in_range(cam_addr, FB_DEPTH);
        end else if (gfx_grant) begin
          addr_d = gfx_addr;
          data_d = gfx_data;
          we_d   = fb_in_range(gfx_addr, FB_DEPTH);
          oob_d  = oob_q || !fb_in_range(gfx_addr, FB_DEPTH);
        end
        // A grant in the clr_start cycle is still written: it lands in the
        // first CLEAR cycle, and fill writes trail the counter by one cycle.
        if (clr_start) begin
          state_d = CLEAR;
          fill_d  = '0;
          color_d = clr_color;
        end
      end
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = fill_q;
        data_d = color_q;
        fill_d = fill_q + 1'b1;
        if (fill_q == LAST_ADDR) begin
          state_d = ARB;
          done_d  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Saturating count of cycles gfx has waited; keeps counting while a fill
  // blocks it, so a long-stalled overlay wins the first ARB cycle.
  always_comb begin
    starve_d = starve_q;
    if (gfx_grant)
      starve_d = '0;
    else if (gfx_valid && starve_q != STARVE_MAX)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB;
      fill_q   <= '0;
      color_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      color_q  <= color_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
      oob_q    <= oob_d;
    end
  end

  assign fb_we    = we_q;
  assign fb_wAddr = addr_q;
  assign fb_wData = data_q;
  assign clr_busy = (state_q == CLEAR);
  assign clr_done = done_q;
  assign oob_err  = oob_q;

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter FB_DEPTH, default 76800, meaning the number of 16-bit frame-buffer words (320 x 240).
REQ-002 Parameter STARVE_LIMIT, default 8, meaning the number of consecutive stalled cycles after which a waiting gfx request wins over cam.
REQ-003 Port clk, input, 1, the single clock for all logic.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port cam_valid / cam_ready, input / output, 1 / 1, camera write handshake.
REQ-006 Port cam_addr / cam_data, input / input, 17 / 16, camera write address and RGB565 pixel.
REQ-007 Port gfx_valid / gfx_ready, input / output, 1 / 1, overlay (braille drawing) write handshake.
REQ-008 Port gfx_addr / gfx_data, input / input, 17 / 16, overlay write address and pixel.
REQ-009 Port clr_start, input, 1, single-cycle pulse that requests a full-buffer fill.
REQ-010 Port clr_color, input, 16, fill colour, sampled in the clr_start cycle.
REQ-011 Port clr_busy / clr_done, output / output, 1 / 1, fill in progress / single-cycle completion pulse.
REQ-012 Port fb_we / fb_wAddr / fb_wData, output / output / output, 1 / 17 / 16, registered drive of the frame-buffer write port.
REQ-013 Port oob_err, output, 1, sticky flag set when an out-of-range address is accepted.

Function
REQ-014 The FSM SHALL have two states: ARB (reset state) and CLEAR.
REQ-015 A transfer SHALL occur in a cycle where valid and ready are both 1; ready SHALL be combinational from state, valid and the starve counter, and SHALL NOT depend on the same requester's address or data.
REQ-016 In ARB, cam SHALL have priority: cam_ready = 1 and gfx_ready = !cam_valid, except under REQ-017.
REQ-017 A 4-bit starve counter SHALL increment (saturating) each cycle where gfx_valid=1 and gfx is not granted, and SHALL clear on a gfx grant; when it is >= STARVE_LIMIT, gfx_ready SHALL be 1 and cam_ready SHALL be 0 for that cycle.
REQ-018 A granted transfer SHALL appear on fb_we/fb_wAddr/fb_wData exactly one cycle later (latency 1); fb_we SHALL be 0 in every other cycle of ARB.
REQ-019 A granted transfer with address >= FB_DEPTH SHALL complete the handshake, SHALL produce fb_we = 0, and SHALL set oob_err, which stays 1 until reset.
REQ-020 clr_start in ARB SHALL latch clr_color, zero a 17-bit fill counter and enter CLEAR next cycle; a transfer granted in that same cycle SHALL still be written.
REQ-021 In CLEAR, cam_ready and gfx_ready SHALL be 0, clr_busy SHALL be 1, and fb_we SHALL be 1 each cycle with fb_wAddr = counter and fb_wData = latched colour, counter += 1.
REQ-022 After the write of address FB_DEPTH-1 (FB_DEPTH cycles in CLEAR), the FSM SHALL return to ARB and clr_done SHALL pulse for one cycle, aligned to the first ARB cycle.
REQ-023 clr_start asserted while in CLEAR SHALL be ignored (no restart, no colour change).
REQ-024 When both valids are 1 and neither the starve rule nor CLEAR applies, cam SHALL be granted and gfx SHALL hold its request until it is granted.

Reset
REQ-025 reset_n low SHALL force state ARB, fb_we=0, fb_wAddr=0, fb_wData=0, clr_busy=0, clr_done=0, oob_err=0, starve counter=0 and fill counter=0, asynchronously and including mid-CLEAR.
REQ-026 After reset release, the first grant SHALL be possible in the first clock edge with reset_n high.

Structure
REQ-027 FB_WIDTH=320, FB_HEIGHT=240, FB_DEPTH and the state enum {ARB, CLEAR} SHALL live in the shared package fb_pkg.
REQ-028 The design SHALL be a single module with no sub-modules; the frame-buffer memory SHALL be instantiated outside and connected through fb_we/fb_wAddr/fb_wData.

Verification
REQ-029 cam_valid=1 with addr=5, data=16'hF800 for one cycle -> cam_ready=1; next cycle fb_we=1, fb_wAddr=5, fb_wData=16'hF800.
REQ-030 cam_valid and gfx_valid held at 1 for 12 cycles -> gfx is granted in cycle 9 only (cam_ready=0 that cycle); the counter resets and cam resumes.
REQ-031 gfx_valid with addr=76800 -> handshake completes, fb_we stays 0, and oob_err=1 until reset.
REQ-032 clr_start with clr_color=16'h001F -> 76800 consecutive fb_we pulses on addresses 0..76799 with data 16'h001F; clr_done pulses once; both readies are 0 throughout.
REQ-033 clr_start pulsed again at fill count 1000 -> ignored; fill completes at 76800 writes.
REQ-034 reset_n asserted at fill count 500 -> all outputs return to reset values immediately; after release, a cam write is accepted on the first edge.
